mem_lsu: RTL and testbench

- Load/store initiator that drives the 64-bit byte-addressed RAM port (we, addr, data_in, registered data_out).
- Turns CPU load/store requests of 1/2/4/8 bytes into RAM transactions.
- Sub-dword stores become read-modify-write, because the RAM writes only full 8-byte words.
- Sits between the execute stage and the RAM; one request in flight at a time.

---
 rtl/mem_lsu_pkg.sv | 24 ++
 rtl/lsu_bytelane.sv | 39 +++
 rtl/mem_lsu.sv | 152 +++++++++++++++
 tb/tb_mem_lsu.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: shared size encodings, FSM state type and size helper for
// the load/store unit.
package mem_lsu_pkg;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    RD   = 3'd1,
    CAP  = 3'd2,
    WR   = 3'd3,
    RESP = 3'd4,
    ERR  = 3'd5
  } state_e;

  // Number of bytes touched by an access of the given size (1/2/4/8).
  function automatic logic [3:0] size_bytes(input logic [1:0] sz);
    return 4'd1 << sz;
  endfunction

endpackage

// File: rtl/lsu_bytelane.sv
// lsu_bytelane: combinational byte-lane steering for the LSU.
//   - load path: keep the low 2^size bytes of the RAM word, sign/zero extend
//   - store path: overlay the low 2^size bytes of wdata onto the RAM word
module lsu_bytelane
  import mem_lsu_pkg::*;
(
  input  logic [63:0] mem_rdata_i,
  input  logic [63:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic        signed_i,
  output logic [63:0] ld_data_o,
  output logic [63:0] st_data_o
);

  logic [7:0] keep;
  logic [8:0] keep9;
  logic       sbit;
  logic [7:0] fill;

  // Byte-keep mask (low 2^size lanes) and the top bit of the loaded field.
  always_comb begin
    keep9 = (9'd1 << size_bytes(size_i)) - 9'd1;
    keep  = keep9[7:0];
    sbit  = 1'b0;
    case (size_i)
      SZ_B:    sbit = mem_rdata_i[7];
      SZ_H:    sbit = mem_rdata_i[15];
      SZ_W:    sbit = mem_rdata_i[31];
      default: sbit = 1'b0; // dword fills every lane, no extension
    endcase
    fill = {8{signed_i & sbit}};
  end

  for (genvar b = 0; b < 8; b++) begin : g_lane
    assign ld_data_o[8*b +: 8] = keep[b] ? mem_rdata_i[8*b +: 8] : fill;
    assign st_data_o[8*b +: 8] = keep[b] ? wdata_i[8*b +: 8] : mem_rdata_i[8*b +: 8];
  end

endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: single-outstanding load/store initiator for a 64-bit,
// byte-addressed RAM with registered read data. Sub-dword stores are
// turned into read-modify-write since the RAM only writes whole words.
// Optional build macro MEM_LSU_ALIGN_CHECK_EN: misaligned accesses fault.
module mem_lsu
  import mem_lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_signed,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [63:0] resp_rdata,
  output logic        mem_we,
  output logic [63:0] mem_addr,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata
);

  // Highest start address: the RAM always touches addr..addr+7.
  localparam logic [63:0] MAX_ADDR = 64'(MEM_BYTES - 8);

  state_e      state_q, state_d;
  logic [1:0]  size_q, size_d;
  logic        sgn_q, sgn_d;
  logic        we_q, we_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] maddr_q, maddr_d;
  logic [63:0] mwdata_q, mwdata_d;
  logic [63:0] rdata_q, rdata_d;

  logic [63:0] ld_data;
  logic [63:0] st_data;
  logic        fault;

  lsu_bytelane u_bytelane (
    .mem_rdata_i (mem_rdata),
    .wdata_i     (wdata_q),
    .size_i      (size_q),
    .signed_i    (sgn_q),
    .ld_data_o   (ld_data),
    .st_data_o   (st_data)
  );

`ifdef MEM_LSU_ALIGN_CHECK_EN
  logic [3:0] nbytes;
  logic       misal;

  // Fault on out-of-range start address or on an address not aligned to 2^size.
  always_comb begin
    nbytes = size_bytes(req_size);
    misal  = |(req_addr[2:0] & (nbytes[2:0] - 3'd1));
    fault  = (req_addr > MAX_ADDR) | misal;
  end
`else
  // Fault only on out-of-range start address; any alignment is legal.
  always_comb begin
    fault = (req_addr > MAX_ADDR);
  end
`endif

  // State and datapath registers; reset aborts any transaction in flight.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      size_q   <= SZ_B;
      sgn_q    <= 1'b0;
      we_q     <= 1'b0;
      wdata_q  <= '0;
      maddr_q  <= '0;
      mwdata_q <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      size_q   <= size_d;
      sgn_q    <= sgn_d;
      we_q     <= we_d;
      wdata_q  <= wdata_d;
      maddr_q  <= maddr_d;
      mwdata_q <= mwdata_d;
      rdata_q  <= rdata_d;
    end
  end

  // Next-state and datapath updates. mem_addr only moves on a good accept,
  // so a faulting address never reaches the RAM and IDLE reads stay harmless.
  always_comb begin
    state_d  = state_q;
    size_d   = size_q;
    sgn_d    = sgn_q;
    we_d     = we_q;
    wdata_d  = wdata_q;
    maddr_d  = maddr_q;
    mwdata_d = mwdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          size_d  = req_size;
          sgn_d   = req_signed;
          we_d    = req_we;
          wdata_d = req_wdata;
          rdata_d = '0;
          if (fault) begin
            state_d = ERR;
          end else begin
            maddr_d = req_addr;
            if (req_we && req_size == SZ_D) begin
              // Full-word store needs no read of the old contents.
              mwdata_d = req_wdata;
              state_d  = WR;
            end else begin
              state_d = RD;
            end
          end
        end
      end
      RD:   state_d = CAP;
      CAP: begin
        if (we_q) begin
          mwdata_d = st_data;
          state_d  = WR;
        end else begin
          rdata_d = ld_data;
          state_d = RESP;
        end
      end
      WR:      state_d = RESP;
      RESP:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decode straight from state so mem_we drops the instant reset hits.
  assign req_ready  = (state_q == IDLE);
  assign resp_valid = (state_q == RESP) || (state_q == ERR);
  assign resp_err   = (state_q == ERR);
  assign mem_we     = (state_q == WR);
  assign mem_addr   = maddr_q;
  assign mem_wdata  = mwdata_q;
  assign resp_rdata = rdata_q;

endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed checks of mem_lsu against a behavioural RAM with
// registered read data. Build with MEM_LSU_ALIGN_CHECK_EN to match the DUT.
module tb_mem_lsu;

  localparam int MB = 1024;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'd0;
  logic        req_signed = 1'b0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_err;
  logic [63:0] resp_rdata;
  logic        mem_we;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata = '0;

  logic [7:0] ram [MB] = '{default: 8'h00};

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_lsu #(.MEM_BYTES(MB)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_signed (req_signed),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_err   (resp_err),
    .resp_rdata (resp_rdata),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Little-endian word RAM: byte k at addr+k, registered read port.
  always @(posedge clk) begin
    if (mem_addr <= 64'(MB - 8)) begin
      for (int k = 0; k < 8; k++) begin
        if (mem_we) ram[int'(mem_addr[15:0]) + k] <= mem_wdata[8*k +: 8];
        mem_rdata[8*k +: 8] <= ram[int'(mem_addr[15:0]) + k];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Issue one request and follow it to resp_valid. lat counts cycles from the
  // accept edge; wem bit i = mem_we seen i+1 cycles after accept.
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg,
                        input logic [63:0] a, input logic [63:0] wd,
                        output int lat, output logic err, output logic [63:0] rd,
                        output logic [15:0] wem, output logic [63:0] wseen,
                        output logic [63:0] raddr);
    @(negedge clk);
    chk("req_ready", {63'd0, req_ready}, 64'd1);
    req_we = we; req_size = sz; req_signed = sg; req_addr = a; req_wdata = wd;
    req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    req_wdata = '1; // later request inputs must be ignored
    lat = 0; err = 1'b0; rd = '0; wem = '0; wseen = '0; raddr = '1;
    while (1) begin
      @(negedge clk);
      lat++;
      if (lat == 1) raddr = mem_addr;
      if (mem_we) begin
        wem[lat-1] = 1'b1;
        wseen = mem_wdata;
      end
      if (resp_valid) begin
        err = resp_err;
        rd  = resp_rdata;
        break;
      end
      if (lat >= 15) begin
        chk("resp_timeout", {63'd0, resp_valid}, 64'd1);
        break;
      end
    end
  endtask

  int          lat, n;
  logic        err, seen;
  logic [63:0] rd, ws, ra;
  logic [15:0] wem;

  initial begin
    // Reset state
    #12;
    chk("rst_ready", {63'd0, req_ready}, 64'd1);
    chk("rst_rv",    {63'd0, resp_valid}, 64'd0);
    chk("rst_err",   {63'd0, resp_err}, 64'd0);
    chk("rst_we",    {63'd0, mem_we}, 64'd0);
    chk("rst_rdata", resp_rdata, 64'd0);
    chk("rst_maddr", mem_addr, 64'd0);
    chk("rst_mwdata", mem_wdata, 64'd0);
    @(negedge clk) rst = 1'b0;

    // Dword store: direct write, single mem_we pulse
    do_req(1'b1, 2'd3, 1'b0, 64'h40, 64'h1122334455667788, lat, err, rd, wem, ws, ra);
    chk("std_lat", lat, 2);
    chk("std_err", {63'd0, err}, 0);
    chk("std_we",  {48'd0, wem}, 64'h0001);
    chk("std_wdata", ws, 64'h1122334455667788);
    chk("std_rdata", rd, 0);

    // Dword load
    do_req(1'b0, 2'd3, 1'b0, 64'h40, 64'h0, lat, err, rd, wem, ws, ra);
    chk("ldd_lat", lat, 3);
    chk("ldd_data", rd, 64'h1122334455667788);
    chk("ldd_we", {48'd0, wem}, 0);
    chk("ldd_addr", ra, 64'h40);
    @(negedge clk); @(negedge clk);
    chk("ldd_hold", resp_rdata, 64'h1122334455667788);

    // Word and signed half loads on the original word
    do_req(1'b0, 2'd2, 1'b0, 64'h40, 64'h0, lat, err, rd, wem, ws, ra);
    chk("ldw_data", rd, 64'h0000000055667788);
    do_req(1'b0, 2'd1, 1'b1, 64'h40, 64'h0, lat, err, rd, wem, ws, ra);
    chk("ldh_s_data", rd, 64'h0000000000007788);

    // Byte store via RMW; only the low wdata byte may be used
    do_req(1'b1, 2'd0, 1'b0, 64'h42, 64'hDEADBEEFCAFE12AB, lat, err, rd, wem, ws, ra);
    chk("stb_lat", lat, 4);
    chk("stb_we", {48'd0, wem}, 64'h0004);
    chk("stb_addr", ra, 64'h42);
    chk("stb_merge", ws, 64'h00001122334455AB);
    chk("stb_rdata", rd, 0);

    do_req(1'b0, 2'd3, 1'b0, 64'h40, 64'h0, lat, err, rd, wem, ws, ra);
    chk("rmw_data", rd, 64'h1122334455AB7788);

    do_req(1'b0, 2'd0, 1'b1, 64'h42, 64'h0, lat, err, rd, wem, ws, ra);
    chk("ldb_s_data", rd, 64'hFFFFFFFFFFFFFFAB);
    do_req(1'b0, 2'd0, 1'b0, 64'h42, 64'h0, lat, err, rd, wem, ws, ra);
    chk("ldb_u_data", rd, 64'h00000000000000AB);

    // Half store + negative signed half load
    do_req(1'b1, 2'd1, 1'b0, 64'h48, 64'h0000000000008001, lat, err, rd, wem, ws, ra);
    chk("sth_merge", ws, 64'h0000000000008001);
    do_req(1'b0, 2'd1, 1'b1, 64'h48, 64'h0, lat, err, rd, wem, ws, ra);
    chk("ldh_neg", rd, 64'hFFFFFFFFFFFF8001);

    // Word store + signed/unsigned word loads, signed dword ignores sign
    do_req(1'b1, 2'd2, 1'b0, 64'h50, 64'h0123456789ABCDEF, lat, err, rd, wem, ws, ra);
    chk("stw_lat", lat, 4);
    do_req(1'b0, 2'd2, 1'b1, 64'h50, 64'h0, lat, err, rd, wem, ws, ra);
    chk("ldw_neg", rd, 64'hFFFFFFFF89ABCDEF);
    do_req(1'b0, 2'd2, 1'b0, 64'h50, 64'h0, lat, err, rd, wem, ws, ra);
    chk("ldw_u", rd, 64'h0000000089ABCDEF);
    do_req(1'b0, 2'd3, 1'b1, 64'h50, 64'h0, lat, err, rd, wem, ws, ra);
    chk("ldd_s", rd, 64'h0000000089ABCDEF);

    // Bounds: 0x3F8 is the last legal start, 0x3F9 faults
    do_req(1'b0, 2'd3, 1'b0, 64'h3F8, 64'h0, lat, err, rd, wem, ws, ra);
    chk("edge_lat", lat, 3);
    chk("edge_err", {63'd0, err}, 0);
    do_req(1'b0, 2'd3, 1'b0, 64'h40, 64'h0, lat, err, rd, wem, ws, ra);
    do_req(1'b0, 2'd0, 1'b0, 64'h3F9, 64'h0, lat, err, rd, wem, ws, ra);
    chk("flt_lat", lat, 1);
    chk("flt_err", {63'd0, err}, 1);
    chk("flt_rdata", rd, 0);
    chk("flt_we", {48'd0, wem}, 0);
    chk("flt_addr_hold", ra, 64'h40);
    do_req(1'b1, 2'd3, 1'b0, 64'h400, 64'hFFFF0000FFFF0000, lat, err, rd, wem, ws, ra);
    chk("flt_st_err", {63'd0, err}, 1);
    chk("flt_st_we", {48'd0, wem}, 0);

    // Misaligned half load
    do_req(1'b0, 2'd1, 1'b0, 64'h41, 64'h0, lat, err, rd, wem, ws, ra);
`ifdef MEM_LSU_ALIGN_CHECK_EN
    chk("mis_err", {63'd0, err}, 1);
    chk("mis_lat", lat, 1);
    chk("mis_rdata", rd, 0);
`else
    chk("mis_err", {63'd0, err}, 0);
    chk("mis_lat", lat, 3);
    chk("mis_rdata", rd, 64'h000000000000AB77);
`endif

    // Reset while the RMW write is on the RAM port: write is lost, no response
    @(negedge clk);
    req_we = 1'b1; req_size = 2'd0; req_signed = 1'b0; req_addr = 64'h44;
    req_wdata = 64'h5A; req_valid = 1'b1;
    @(posedge clk);
    #1 req_valid = 1'b0;
    n = 0;
    while (!mem_we && n < 8) begin
      @(negedge clk);
      n++;
    end
    chk("rst_wr_reach", {63'd0, mem_we}, 1);
    chk("rst_wr_cyc", n, 3);
    rst = 1'b1;
    #1;
    chk("rstwr_we", {63'd0, mem_we}, 0);
    chk("rstwr_ready", {63'd0, req_ready}, 1);
    chk("rstwr_rv", {63'd0, resp_valid}, 0);
    seen = 1'b0;
    @(negedge clk);
    if (resp_valid) seen = 1'b1;
    rst = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (resp_valid) seen = 1'b1;
    end
    chk("rstwr_no_resp", {63'd0, seen}, 0);

    do_req(1'b0, 2'd3, 1'b0, 64'h40, 64'h0, lat, err, rd, wem, ws, ra);
    chk("post_rst_lat", lat, 3);
    chk("post_rst_data", rd, 64'h1122334455AB7788);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
